// File: rtl/best_neighbor_scan.sv
// Scans a neighbour Q-value table, tracks the strongest neighbour and counts those above our own Q.
// Define BETTER_LIST_EN to also write the IDs of the first BETTER_MAX better neighbours back to memory.
module best_neighbor_scan #(
    parameter logic [15:0] QVALUE_BASE   = 16'h01C8,
    parameter logic [15:0] NEIGHBOR_BASE = 16'h0048,
    parameter logic [15:0] BETTER_BASE   = 16'h0658,
    parameter int unsigned BETTER_MAX    = 8
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        start,
    input  logic [6:0]  num_neighbors,
    input  logic [15:0] my_qvalue,
    output logic [15:0] address,
    output logic        wr_en,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    output logic [15:0] best_value,
    output logic [15:0] best_neighbor_id,
    output logic [5:0]  best_index,
    output logic        best_valid,
    output logic [6:0]  better_count,
    output logic        busy,
    output logic        done
);

`ifdef BETTER_LIST_EN
    localparam bit ListEn = 1'b1;
`else
    localparam bit ListEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StRdQ,
        StLatchQ,
        StLatchId,
        StWrBetter,
        StDone
    } state_t;

    state_t      state;
    logic [5:0]  idx;
    logic [5:0]  last_idx;
    logic [15:0] q_val;

    logic        improves;
    logic        better;
    logic        can_write;
    logic        is_last;
    logic [5:0]  idx_inc;

    // Table entries are 16-bit words, so entry k sits at base + 2*k.
    function automatic logic [15:0] word_off(input logic [6:0] k);
        return {8'd0, k, 1'b0};
    endfunction

    always_comb begin
        improves  = !best_valid || (q_val > best_value);
        better    = q_val > my_qvalue;
        can_write = ListEn && better && (32'(better_count) < BETTER_MAX);
        is_last   = idx == last_idx;
        idx_inc   = idx + 6'd1;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state            <= StIdle;
            idx              <= 6'd0;
            last_idx         <= 6'd0;
            q_val            <= 16'd0;
            address          <= 16'd0;
            wr_en            <= 1'b0;
            mem_data_in      <= 16'd0;
            best_value       <= 16'd0;
            best_neighbor_id <= 16'hFFFF;
            best_index       <= 6'd0;
            best_valid       <= 1'b0;
            better_count     <= 7'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        idx              <= 6'd0;
                        last_idx         <= (num_neighbors >= 7'd64) ? 6'd63
                                                                     : num_neighbors[5:0] - 6'd1;
                        best_value       <= 16'd0;
                        best_neighbor_id <= 16'hFFFF;
                        best_index       <= 6'd0;
                        best_valid       <= 1'b0;
                        better_count     <= 7'd0;
                        if (num_neighbors != 7'd0) begin
                            state   <= StRdQ;
                            busy    <= 1'b1;
                            address <= QVALUE_BASE;
                        end else begin
                            state <= StDone;
                        end
                    end
                end
                StRdQ: begin
                    address <= NEIGHBOR_BASE + word_off({1'b0, idx});
                    state   <= StLatchQ;
                end
                StLatchQ: begin
                    q_val   <= mem_data_out;
                    address <= 16'd0;
                    state   <= StLatchId;
                end
                StLatchId: begin
                    // Strict compare keeps the lowest index on ties.
                    if (improves) begin
                        best_value       <= q_val;
                        best_neighbor_id <= mem_data_out;
                        best_index       <= idx;
                        best_valid       <= 1'b1;
                    end
                    if (better && better_count != 7'd64) begin
                        better_count <= better_count + 7'd1;
                    end
                    if (can_write) begin
                        state       <= StWrBetter;
                        wr_en       <= 1'b1;
                        address     <= BETTER_BASE + word_off(better_count);
                        mem_data_in <= mem_data_out;
                    end else if (is_last) begin
                        state   <= StDone;
                        busy    <= 1'b0;
                        address <= 16'd0;
                    end else begin
                        idx     <= idx_inc;
                        state   <= StRdQ;
                        address <= QVALUE_BASE + word_off({1'b0, idx_inc});
                    end
                end
                StWrBetter: begin
                    wr_en       <= 1'b0;
                    mem_data_in <= 16'd0;
                    if (is_last) begin
                        state   <= StDone;
                        busy    <= 1'b0;
                        address <= 16'd0;
                    end else begin
                        idx     <= idx_inc;
                        state   <= StRdQ;
                        address <= QVALUE_BASE + word_off({1'b0, idx_inc});
                    end
                end
                StDone: begin
                    done  <= 1'b1;
                    state <= StIdle;
                end
                default: begin
                    state   <= StIdle;
                    busy    <= 1'b0;
                    wr_en   <= 1'b0;
                    address <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_best_neighbor_scan.sv
// Directed bench for best_neighbor_scan: word memory model, latency, results and write-back list.
module tb_best_neighbor_scan;

`ifdef BETTER_LIST_EN
    localparam bit ListEn = 1'b1;
`else
    localparam bit ListEn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        nreset;
    logic        start;
    logic [6:0]  num_neighbors;
    logic [15:0] my_qvalue;
    logic [15:0] address;
    logic        wr_en;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic [15:0] best_value;
    logic [15:0] best_neighbor_id;
    logic [5:0]  best_index;
    logic        best_valid;
    logic [6:0]  better_count;
    logic        busy;
    logic        done;

    int checks = 0;
    int fails  = 0;
    int done_cnt = 0;

    logic [15:0] mem [0:32767];
    logic [15:0] wr_a[$];
    logic [15:0] wr_d[$];
    logic [15:0] last_rd;

    best_neighbor_scan dut (
        .clock            (clock),
        .nreset           (nreset),
        .start            (start),
        .num_neighbors    (num_neighbors),
        .my_qvalue        (my_qvalue),
        .address          (address),
        .wr_en            (wr_en),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out),
        .best_value       (best_value),
        .best_neighbor_id (best_neighbor_id),
        .best_index       (best_index),
        .best_valid       (best_valid),
        .better_count     (better_count),
        .busy             (busy),
        .done             (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (wr_en) begin
            mem[address[15:1]] <= mem_data_in;
            wr_a.push_back(address);
            wr_d.push_back(mem_data_in);
        end else if (address != 16'd0) begin
            last_rd <= address;
        end
        mem_data_out <= mem[address[15:1]];
    end

    always @(negedge clock) if (done) done_cnt++;

    // Entry i: q at 0x01C8 + 2i, id at 0x0048 + 2i.
    task automatic set_entry(input int i, input logic [15:0] q, input logic [15:0] id);
        mem[16'h00E4 + i] = q;
        mem[16'h0024 + i] = id;
    endtask

    task automatic run_scan(input logic [6:0] n, input logic [15:0] myq,
                            output int lat, output logic busy0);
        wr_a.delete();
        wr_d.delete();
        last_rd  = 16'd0;
        done_cnt = 0;
        @(negedge clock);
        num_neighbors = n;
        my_qvalue     = myq;
        start         = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        busy0 = busy;
        lat   = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic load_basic();
        set_entry(0, 16'd5, 16'd10);
        set_entry(1, 16'd9, 16'd11);
        set_entry(2, 16'd9, 16'd12);
        set_entry(3, 16'd2, 16'd13);
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        start = 1'b0;
        num_neighbors = 7'd0;
        my_qvalue = 16'd0;
        #12;
        checks++; if (best_neighbor_id !== 16'hFFFF) begin fails++;
            $display("FAIL reset_id: got %h want ffff", best_neighbor_id); end
        checks++; if ({best_value, best_index, best_valid, better_count} !== 30'd0) begin fails++;
            $display("FAIL reset_results: got %h %h %b %h want 0", best_value, best_index,
                     best_valid, better_count); end
        checks++; if ({busy, done, wr_en, address, mem_data_in} !== 35'd0) begin fails++;
            $display("FAIL reset_ctrl: got busy=%b done=%b wr=%b addr=%h din=%h want 0", busy,
                     done, wr_en, address, mem_data_in); end
        @(negedge clock);
        nreset = 1'b1;
    endtask

    task automatic test_empty();
        int lat;
        logic b0;
        run_scan(7'd0, 16'd0, lat, b0);
        checks++; if (lat != 1) begin fails++;
            $display("FAIL empty_latency: got %0d want 1", lat); end
        checks++; if (best_valid !== 1'b0 || best_neighbor_id !== 16'hFFFF) begin fails++;
            $display("FAIL empty_results: got valid=%b id=%h want 0/ffff", best_valid,
                     best_neighbor_id); end
        checks++; if (better_count !== 7'd0 || wr_a.size() != 0) begin fails++;
            $display("FAIL empty_count: got count=%0d writes=%0d want 0/0", better_count,
                     wr_a.size()); end
        checks++; if (done_cnt != 1) begin fails++;
            $display("FAIL empty_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic check_basic(input string tag, input int lat);
        int exp_lat = ListEn ? 15 : 13;
        checks++; if (lat != exp_lat) begin fails++;
            $display("FAIL %s_latency: got %0d want %0d", tag, lat, exp_lat); end
        checks++; if (best_value !== 16'd9 || best_neighbor_id !== 16'd11) begin fails++;
            $display("FAIL %s_best: got %0d/%0d want 9/11", tag, best_value, best_neighbor_id); end
        checks++; if (best_index !== 6'd1 || best_valid !== 1'b1) begin fails++;
            $display("FAIL %s_index: got %0d valid=%b want 1/1", tag, best_index, best_valid); end
        checks++; if (better_count !== 7'd2) begin fails++;
            $display("FAIL %s_count: got %0d want 2", tag, better_count); end
        checks++; if (busy !== 1'b0 || done_cnt != 1) begin fails++;
            $display("FAIL %s_done: got busy=%b pulses=%0d want 0/1", tag, busy, done_cnt); end
        if (ListEn) begin
            checks++;
            if (wr_a.size() != 2 || wr_a[0] !== 16'h0658 || wr_d[0] !== 16'd11 ||
                wr_a[1] !== 16'h065A || wr_d[1] !== 16'd12) begin fails++;
                $display("FAIL %s_writes: got %0d writes want 11@658 12@65a", tag, wr_a.size());
            end
        end else begin
            checks++; if (wr_a.size() != 0) begin fails++;
                $display("FAIL %s_writes: got %0d want 0", tag, wr_a.size()); end
        end
    endtask

    task automatic test_basic();
        int lat;
        logic b0;
        load_basic();
        run_scan(7'd4, 16'd6, lat, b0);
        checks++; if (b0 !== 1'b1) begin fails++;
            $display("FAIL basic_busy: got %b want 1", b0); end
        check_basic("basic", lat);
    endtask

    task automatic test_ties();
        int lat;
        logic b0;
        for (int i = 0; i < 3; i++) set_entry(i, 16'd7, 16'h0020 + 16'(i));
        run_scan(7'd3, 16'd7, lat, b0);
        checks++; if (lat != 10) begin fails++;
            $display("FAIL ties_latency: got %0d want 10", lat); end
        checks++; if (best_index !== 6'd0 || best_neighbor_id !== 16'h0020) begin fails++;
            $display("FAIL ties_lowest: got %0d/%h want 0/0020", best_index, best_neighbor_id); end
        checks++; if (better_count !== 7'd0) begin fails++;
            $display("FAIL ties_strict: got %0d want 0", better_count); end
    endtask

    task automatic check_full(input string tag, input int lat);
        int exp_lat = ListEn ? 201 : 193;
        checks++; if (lat != exp_lat) begin fails++;
            $display("FAIL %s_latency: got %0d want %0d", tag, lat, exp_lat); end
        checks++; if (best_value !== 16'd63 || best_index !== 6'd63 ||
                      best_neighbor_id !== 16'h013F) begin fails++;
            $display("FAIL %s_best: got %0d idx=%0d id=%h want 63/63/013f", tag, best_value,
                     best_index, best_neighbor_id); end
        checks++; if (better_count !== 7'd63) begin fails++;
            $display("FAIL %s_count: got %0d want 63", tag, better_count); end
        if (ListEn) begin
            checks++; if (wr_a.size() != 8) begin fails++;
                $display("FAIL %s_nwrites: got %0d want 8", tag, wr_a.size()); end
            for (int k = 0; k < 8 && k < wr_a.size(); k++) begin
                checks++;
                if (wr_a[k] !== 16'h0658 + 16'(2 * k) || wr_d[k] !== 16'h0101 + 16'(k)) begin
                    fails++;
                    $display("FAIL %s_write%0d: got %h@%h want %h@%h", tag, k, wr_d[k], wr_a[k],
                             16'h0101 + 16'(k), 16'h0658 + 16'(2 * k));
                end
            end
        end else begin
            checks++; if (wr_a.size() != 0) begin fails++;
                $display("FAIL %s_writes: got %0d want 0", tag, wr_a.size()); end
        end
    endtask

    task automatic test_full64();
        int lat;
        logic b0;
        for (int i = 0; i < 64; i++) set_entry(i, 16'(i), 16'h0100 + 16'(i));
        run_scan(7'd64, 16'd0, lat, b0);
        check_full("full", lat);
    endtask

    task automatic test_clamp();
        int lat;
        logic b0;
        set_entry(64, 16'hFFFF, 16'hDEAD);
        run_scan(7'd100, 16'd0, lat, b0);
        check_full("clamp", lat);
        checks++; if (last_rd !== 16'h00C6) begin fails++;
            $display("FAIL clamp_last_addr: got %h want 00c6", last_rd); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic b0;
        load_basic();
        done_cnt = 0;
        @(negedge clock);
        num_neighbors = 7'd4;
        my_qvalue = 16'd6;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(posedge clock);
        #2 nreset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || best_valid !== 1'b0 || best_neighbor_id !== 16'hFFFF ||
                      best_value !== 16'd0 || address !== 16'd0) begin fails++;
            $display("FAIL midreset_outputs: got busy=%b valid=%b id=%h val=%h addr=%h", busy,
                     best_valid, best_neighbor_id, best_value, address); end
        repeat (2) @(negedge clock);
        nreset = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        checks++; if (done_cnt != 0) begin fails++;
            $display("FAIL midreset_nodone: got %0d pulses want 0", done_cnt); end
        run_scan(7'd4, 16'd6, lat, b0);
        check_basic("rerun", lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        int exp_lat = ListEn ? 15 : 13;
        load_basic();
        wr_a.delete();
        wr_d.delete();
        done_cnt = 0;
        @(negedge clock);
        num_neighbors = 7'd4;
        my_qvalue = 16'd6;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = c;
                break;
            end
            if (c == 4 || c == 5 || c == exp_lat - 1) begin
                start = 1'b1;
                num_neighbors = 7'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check_basic("b2b", lat);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'd0;
        test_reset();
        test_empty();
        test_basic();
        test_ties();
        test_full64();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
